// File: rtl/spec_block_detect.sv
// Per-path CF-Log matcher: compares logged src/dest entries against a programmed path
// and emits a registered one-cycle detect pulse. Optional repeat counter: SPEC_LOOP_CTR_EN.
module spec_block_detect #(
    parameter int          MAX_LEN  = 8,
    parameter int          IDX_W    = 3,
    parameter logic [7:0]  BLOCK_ID = 8'h01
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cflow_hw_wen,
    input  logic [15:0]      cflow_log_ptr,
    input  logic [15:0]      cflow_src,
    input  logic [15:0]      cflow_dest,
    input  logic             cfg_wen,
    input  logic [IDX_W-1:0] cfg_idx,
    input  logic [15:0]      cfg_src,
    input  logic [15:0]      cfg_dest,
    input  logic [IDX_W:0]   cfg_len,
    input  logic             cfg_commit,
    output logic             path_valid,
    output logic             detect_active,
    output logic [7:0]       active_block_id,
    output logic [15:0]      active_block_cflog_addr,
    output logic [IDX_W-1:0] match_idx,
    output logic [15:0]      repeat_count
);

    localparam logic [IDX_W:0] LEN_MAX = (IDX_W+1)'(MAX_LEN);
    localparam logic [IDX_W:0] LEN_ONE = (IDX_W+1)'(1);

    logic [15:0]      src_mem_q  [MAX_LEN];
    logic [15:0]      dest_mem_q [MAX_LEN];
    logic [IDX_W:0]   len_q, len_d;
    logic             path_valid_q, path_valid_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [15:0]      start_q, start_d;
    logic             detect_q, detect_d;
    logic [15:0]      addr_q, addr_d;

    logic             cfg_any, cfg_legal, cont_ok, hit, hit0, last, det;
    logic [IDX_W-1:0] eff_idx;
    logic [15:0]      det_start;

    assign cfg_any   = cfg_wen | cfg_commit;
    assign cfg_legal = (cfg_len != '0) && (cfg_len <= LEN_MAX);
    // A broken pointer sequence (log flush / pointer reset) drops the partial match.
    assign cont_ok   = (idx_q == '0) || (cflow_log_ptr == start_q + 16'(idx_q));
    assign eff_idx   = cont_ok ? idx_q : '0;
    assign hit       = (cflow_src == src_mem_q[eff_idx]) && (cflow_dest == dest_mem_q[eff_idx]);
    assign hit0      = (cflow_src == src_mem_q[0]) && (cflow_dest == dest_mem_q[0]);
    assign last      = ({1'b0, eff_idx} == len_q - LEN_ONE);

    always_comb begin
        len_d        = len_q;
        path_valid_d = path_valid_q;
        idx_d        = idx_q;
        start_d      = start_q;
        det          = 1'b0;
        det_start    = start_q;
        if (cfg_any) begin
            idx_d = '0;
            if (cfg_wen) path_valid_d = 1'b0;
            if (cfg_commit) begin
                path_valid_d = cfg_legal;
                if (cfg_legal) len_d = cfg_len;
            end
        end else if (cflow_hw_wen && path_valid_q) begin
            if (hit) begin
                if (last) begin
                    det       = 1'b1;
                    det_start = (eff_idx == '0) ? cflow_log_ptr : start_q;
                    idx_d     = '0;
                    start_d   = det_start;
                end else begin
                    idx_d = eff_idx + 1'b1;
                    if (eff_idx == '0) start_d = cflow_log_ptr;
                end
            end else if ((eff_idx != '0) && hit0) begin
                start_d = cflow_log_ptr;
                if (len_q == LEN_ONE) begin
                    det       = 1'b1;
                    det_start = cflow_log_ptr;
                    idx_d     = '0;
                end else begin
                    idx_d = IDX_W'(1);
                end
            end else begin
                idx_d = '0;
            end
        end
        detect_d = det;
        addr_d   = det ? det_start : 16'h0000;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            len_q        <= '0;
            path_valid_q <= 1'b0;
            idx_q        <= '0;
            start_q      <= '0;
            detect_q     <= 1'b0;
            addr_q       <= '0;
        end else begin
            len_q        <= len_d;
            path_valid_q <= path_valid_d;
            idx_q        <= idx_d;
            start_q      <= start_d;
            detect_q     <= detect_d;
            addr_q       <= addr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                src_mem_q[i]  <= '0;
                dest_mem_q[i] <= '0;
            end
        end else if (cfg_wen && (32'(cfg_idx) < MAX_LEN)) begin
            src_mem_q[cfg_idx]  <= cfg_src;
            dest_mem_q[cfg_idx] <= cfg_dest;
        end
    end

`ifdef SPEC_LOOP_CTR_EN
    logic        miss0;
    logic [15:0] rep_q, rep_d, next_q, next_d;

    assign miss0 = cflow_hw_wen & path_valid_q & ~cfg_any & ~hit & (eff_idx == '0);

    always_comb begin
        rep_d  = rep_q;
        next_d = next_q;
        if (cfg_wen) begin
            rep_d = '0;
        end else if (det) begin
            // rep_q==0 means no live previous detection to be contiguous with
            if ((rep_q != '0) && (det_start == next_q))
                rep_d = (rep_q == 16'hFFFF) ? rep_q : rep_q + 16'd1;
            else
                rep_d = 16'd1;
            next_d = det_start + 16'(len_q);
        end else if (miss0) begin
            rep_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rep_q  <= '0;
            next_q <= '0;
        end else begin
            rep_q  <= rep_d;
            next_q <= next_d;
        end
    end

    assign repeat_count = rep_q;
`else
    assign repeat_count = 16'h0000;
`endif

    assign path_valid              = path_valid_q;
    assign detect_active           = detect_q;
    assign active_block_id         = detect_q ? BLOCK_ID : 8'h00;
    assign active_block_cflog_addr = addr_q;
    assign match_idx               = idx_q;

endmodule
